// File: rtl/fp_pkg.sv
// Shared FP operand definitions: default field widths and the special-value class encoding.
package fp_pkg;

    localparam int unsigned FP_EXP_W = 8;
    localparam int unsigned FP_MAN_W = 24;
    localparam int unsigned CLS_W    = 3;

    // Bit positions inside a class vector; at most one bit is set.
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_INF  = 2'd1,
        CLS_NAN  = 2'd2
    } fp_cls_t;

    localparam logic [CLS_W-1:0] CLS_NORMAL = 3'b000;

endpackage

// File: rtl/fp_operand_skid_stage_if.sv
// Operand-pair handshake bus: upstream valid/ready plus payload in, downstream valid/ready plus held payload out.
interface fp_operand_skid_stage_if #(
    parameter int unsigned EXP_W = fp_pkg::FP_EXP_W,
    parameter int unsigned MAN_W = fp_pkg::FP_MAN_W
);
    logic             in_valid;
    logic             in_ready;
    logic [MAN_W-1:0] a_m;
    logic [MAN_W-1:0] b_m;
    logic [EXP_W-1:0] a_e;
    logic [EXP_W-1:0] b_e;
    logic             a_s;
    logic             b_s;

    logic             out_valid;
    logic             out_ready;
    logic [MAN_W-1:0] a1_m;
    logic [MAN_W-1:0] b1_m;
    logic [EXP_W-1:0] a1_e;
    logic [EXP_W-1:0] b1_e;
    logic             a1_s;
    logic             b1_s;
    logic [2:0]       a1_cls;
    logic [2:0]       b1_cls;

    // Stage side.
    modport slave (
        input  in_valid, a_m, b_m, a_e, b_e, a_s, b_s, out_ready,
        output in_ready, out_valid, a1_m, b1_m, a1_e, b1_e, a1_s, b1_s, a1_cls, b1_cls
    );

    // Environment side (upstream producer plus downstream consumer).
    modport master (
        output in_valid, a_m, b_m, a_e, b_e, a_s, b_s, out_ready,
        input  in_ready, out_valid, a1_m, b1_m, a1_e, b1_e, a1_s, b1_s, a1_cls, b1_cls
    );

endinterface

// File: rtl/fp_classify.sv
// Combinational special-value classifier for one unpacked FP operand (nan/inf/zero one-hot, 0 otherwise).
module fp_classify
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = FP_EXP_W,
    parameter int unsigned MAN_W = FP_MAN_W
) (
    input  logic [EXP_W-1:0] e,
    input  logic [MAN_W-2:0] frac,
    output logic [CLS_W-1:0] cls_c
);

    always_comb begin
        cls_c = CLS_NORMAL;
        if (&e) begin
            if (|frac) begin
                cls_c[CLS_NAN] = 1'b1;
            end else begin
                cls_c[CLS_INF] = 1'b1;
            end
        end else if (~|e && ~|frac) begin
            cls_c[CLS_ZERO] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_operand_skid_stage.sv
// Elastic operand-pair stage: main + skid register for full throughput under backpressure,
// synchronous flush, and registered nan/inf/zero classification travelling with the payload.
module fp_operand_skid_stage
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = FP_EXP_W,
    parameter int unsigned MAN_W = FP_MAN_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    fp_operand_skid_stage_if.slave   bus
);

    localparam int unsigned OP_W  = 1 + EXP_W + MAN_W;
    localparam int unsigned ENT_W = 2 * OP_W + 2 * CLS_W;

    logic [CLS_W-1:0] a_cls_c;
    logic [CLS_W-1:0] b_cls_c;
    logic [ENT_W-1:0] new_ent_c;
    logic             accept_c;

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q,   in_ready_d;
    logic [ENT_W-1:0] main_ent_q,   main_ent_d;
    logic [ENT_W-1:0] skid_ent_q,   skid_ent_d;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .e     (bus.a_e),
        .frac  (bus.a_m[MAN_W-2:0]),
        .cls_c (a_cls_c)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .e     (bus.b_e),
        .frac  (bus.b_m[MAN_W-2:0]),
        .cls_c (b_cls_c)
    );

    assign new_ent_c = {bus.a_s, bus.a_e, bus.a_m, bus.b_s, bus.b_e, bus.b_m, a_cls_c, b_cls_c};
    // Flush takes priority, so an offered pair is never captured in a flush cycle.
    assign accept_c  = bus.in_valid & in_ready_q & ~flush;

    // Main/skid steering: the skid entry always refills main before a newer pair does.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_ent_d   = main_ent_q;
        skid_ent_d   = skid_ent_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || bus.out_ready) begin
            if (skid_valid_q) begin
                main_ent_d   = skid_ent_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept_c;
                if (accept_c) begin
                    skid_ent_d = new_ent_c;
                end
            end else begin
                main_valid_d = accept_c;
                if (accept_c) begin
                    main_ent_d = new_ent_c;
                end
            end
        end else if (accept_c) begin
            skid_ent_d   = new_ent_c;
            skid_valid_d = 1'b1;
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            main_ent_q   <= '0;
            skid_ent_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            main_ent_q   <= main_ent_d;
            skid_ent_q   <= skid_ent_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_valid_q;
    assign {bus.a1_s, bus.a1_e, bus.a1_m, bus.b1_s, bus.b1_e, bus.b1_m, bus.a1_cls, bus.b1_cls} = main_ent_q;

endmodule

// File: tb/tb_fp_operand_skid_stage.sv
// Directed + random bench for fp_operand_skid_stage with a reference FIFO scoreboard.
module tb_fp_operand_skid_stage;

    logic clk;
    logic rst_n;
    logic flush;

    int checks;
    int failures;
    int pops;
    int valid_cycles;
    logic [71:0] q[$];

    fp_operand_skid_stage_if bus ();

    fp_operand_skid_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] cls_f(input logic [7:0] e, input logic [23:0] m);
        logic [22:0] fr;
        fr = m[22:0];
        if (e == 8'hFF) return (fr != 23'd0) ? 3'b100 : 3'b010;
        if (e == 8'h00 && fr == 23'd0) return 3'b001;
        return 3'b000;
    endfunction

    function automatic logic [71:0] in_word();
        return {bus.a_s, bus.a_e, bus.a_m, bus.b_s, bus.b_e, bus.b_m,
                cls_f(bus.a_e, bus.a_m), cls_f(bus.b_e, bus.b_m)};
    endfunction

    function automatic logic [71:0] out_word();
        return {bus.a1_s, bus.a1_e, bus.a1_m, bus.b1_s, bus.b1_e, bus.b1_m, bus.a1_cls, bus.b1_cls};
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_pair(input logic as, input logic [7:0] ae, input logic [23:0] am,
                            input logic bs, input logic [7:0] be, input logic [23:0] bm);
        bus.a_s = as; bus.a_e = ae; bus.a_m = am;
        bus.b_s = bs; bus.b_e = be; bus.b_m = bm;
    endtask

    function automatic logic [7:0] rnd_exp();
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        return 8'($urandom);
    endfunction

    function automatic logic [23:0] rnd_man();
        logic [23:0] m;
        m = 24'($urandom);
        if ($urandom_range(0, 3) == 0) m[22:0] = 23'd0;
        return m;
    endfunction

    task automatic rnd_pair();
        set_pair(1'($urandom_range(0, 1)), rnd_exp(), rnd_man(),
                 1'($urandom_range(0, 1)), rnd_exp(), rnd_man());
    endtask

    // One clock: sample handshakes before the edge, then update the scoreboard and check invariants.
    task automatic tick();
        logic pre_in, pre_out, pre_hold, pre_flush;
        logic [71:0] pre_word, pre_in_word, front;
        pre_in      = bus.in_valid & bus.in_ready;
        pre_out     = bus.out_valid & bus.out_ready;
        pre_hold    = bus.out_valid & ~bus.out_ready & ~flush;
        pre_flush   = flush;
        pre_word    = out_word();
        pre_in_word = in_word();
        @(posedge clk);
        #1;
        if (pre_out) begin
            checks++;
            assert (q.size() != 0) else begin
                failures++;
                $error("FAIL underflow observed=out_transfer expected=no_transfer");
            end
            if (q.size() != 0) begin
                front = q.pop_front();
                chk("order", pre_word, front);
                pops++;
            end
        end
        if (pre_flush) q.delete();
        else if (pre_in) q.push_back(pre_in_word);
        chk("no_overflow", 72'(q.size() <= 2), 72'(1'b1));
        chk("out_valid", 72'(bus.out_valid), 72'(q.size() != 0));
        chk("in_ready", 72'(bus.in_ready), 72'(q.size() < 2));
        if (pre_hold) chk("stable", out_word(), pre_word);
    endtask

    initial begin
        checks = 0; failures = 0; pops = 0; valid_cycles = 0;
        rst_n = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        set_pair(1'b0, 8'h00, 24'h0, 1'b0, 8'h00, 24'h0);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 72'(bus.out_valid), 72'(1'b0));
        chk("rst_in_ready", 72'(bus.in_ready), 72'(1'b1));
        chk("rst_payload", out_word(), 72'd0);
        @(negedge clk) rst_n = 1'b1;

        // Pass-through with hand-computed fields.
        set_pair(1'b0, 8'd127, 24'h800000, 1'b1, 8'd128, 24'hC00000);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        chk("p0_a_s", 72'(bus.a1_s), 72'(1'b0));
        chk("p0_a_e", 72'(bus.a1_e), 72'(8'd127));
        chk("p0_a_m", 72'(bus.a1_m), 72'(24'h800000));
        chk("p0_b_s", 72'(bus.b1_s), 72'(1'b1));
        chk("p0_b_e", 72'(bus.b1_e), 72'(8'd128));
        chk("p0_b_m", 72'(bus.b1_m), 72'(24'hC00000));
        chk("p0_a_cls", 72'(bus.a1_cls), 72'(3'b000));
        chk("p0_b_cls", 72'(bus.b1_cls), 72'(3'b000));
        bus.in_valid = 1'b0;
        tick();

        // 100 back-to-back pairs.
        pops = 0;
        for (int i = 0; i < 100; i++) begin
            rnd_pair();
            bus.in_valid = 1'b1;
            tick();
            if (bus.out_valid) valid_cycles++;
        end
        bus.in_valid = 1'b0;
        tick();
        chk("stream_pops", 72'(pops), 72'(100));
        chk("stream_rate", 72'(valid_cycles), 72'(100));

        // Backpressure: P1,P2 fill main+skid, P3 stalls.
        bus.out_ready = 1'b0;
        set_pair(1'b0, 8'd1, 24'h800001, 1'b0, 8'd1, 24'h800000);
        bus.in_valid = 1'b1;
        tick();
        chk("bp_p1_out", 72'(bus.a1_m), 72'(24'h800001));
        chk("bp_p1_ready", 72'(bus.in_ready), 72'(1'b1));
        bus.a_m = 24'h800002;
        tick();
        chk("bp_p2_ready", 72'(bus.in_ready), 72'(1'b0));
        chk("bp_p2_hold", 72'(bus.a1_m), 72'(24'h800001));
        bus.a_m = 24'h800003;
        repeat (2) tick();
        chk("bp_p3_stall", 72'(bus.in_ready), 72'(1'b0));
        chk("bp_p3_hold", 72'(bus.a1_m), 72'(24'h800001));
        bus.out_ready = 1'b1;
        tick();
        chk("bp_rel_p2", 72'(bus.a1_m), 72'(24'h800002));
        chk("bp_rel_ready", 72'(bus.in_ready), 72'(1'b1));
        tick();
        chk("bp_rel_p3", 72'(bus.a1_m), 72'(24'h800003));
        chk("bp_rel_p3_valid", 72'(bus.out_valid), 72'(1'b1));
        bus.in_valid = 1'b0;
        tick();
        chk("bp_empty", 72'(bus.out_valid), 72'(1'b0));

        // Classification corners.
        bus.in_valid = 1'b1;
        set_pair(1'b0, 8'hFF, 24'h800001, 1'b0, 8'h00, 24'h000001);
        tick();
        chk("cls_nan", 72'(bus.a1_cls), 72'(3'b100));
        chk("cls_subnormal", 72'(bus.b1_cls), 72'(3'b000));
        set_pair(1'b1, 8'hFF, 24'h800000, 1'b0, 8'hFF, 24'h000000);
        tick();
        chk("cls_inf_a", 72'(bus.a1_cls), 72'(3'b010));
        chk("cls_inf_b", 72'(bus.b1_cls), 72'(3'b010));
        set_pair(1'b0, 8'h00, 24'h000000, 1'b1, 8'h80, 24'h000000);
        tick();
        chk("cls_zero", 72'(bus.a1_cls), 72'(3'b001));
        chk("cls_norm_b", 72'(bus.b1_cls), 72'(3'b000));
        bus.in_valid = 1'b0;
        tick();

        // Flush with both entries full and a pair offered.
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        set_pair(1'b0, 8'd5, 24'hA00001, 1'b0, 8'd5, 24'h800000);
        tick();
        bus.a_m = 24'hA00002;
        tick();
        bus.a_m = 24'hA00003;
        flush = 1'b1;
        tick();
        chk("flush_full_valid", 72'(bus.out_valid), 72'(1'b0));
        chk("flush_full_ready", 72'(bus.in_ready), 72'(1'b1));
        flush = 1'b0; bus.in_valid = 1'b0;
        tick();
        chk("flush_full_idle", 72'(bus.out_valid), 72'(1'b0));
        // Flush while the offered pair would otherwise be accepted.
        bus.in_valid = 1'b1; bus.a_m = 24'hA00004;
        tick();
        bus.a_m = 24'hA00005;
        flush = 1'b1;
        tick();
        chk("flush_acc_valid", 72'(bus.out_valid), 72'(1'b0));
        chk("flush_acc_ready", 72'(bus.in_ready), 72'(1'b1));
        flush = 1'b0; bus.in_valid = 1'b0;
        tick();
        chk("flush_acc_dropped", 72'(bus.out_valid), 72'(1'b0));
        bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.a_m = 24'hA00006;
        tick();
        chk("flush_after", 72'(bus.a1_m), 72'(24'hA00006));
        bus.in_valid = 1'b0;
        tick();

        // Asynchronous reset mid-stream.
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.a_m = 24'hB00001;
        tick();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 72'(bus.out_valid), 72'(1'b0));
        chk("arst_in_ready", 72'(bus.in_ready), 72'(1'b1));
        chk("arst_payload", out_word(), 72'd0);
        bus.in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Random traffic against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            flush         = ($urandom_range(0, 63) == 0);
            rnd_pair();
            tick();
        end
        flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("final_drained", 72'(q.size()), 72'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
